// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
// Shares the single register-file port between two masters: master 0 (I2C
// slave) and master 1 (SPI slave). Each master fires one-cycle rd/wr strobes
// with no back-pressure. Every strobe lands in a one-deep pending slot for
// that master, and at most one slot is issued to the register file per
// cycle. Read data comes back one cycle after s_rd. It is steered to the
// master that issued the read and flagged with a one-cycle rvalid pulse.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   m0_*/m1_*             master side: addr, wdata, wr/rd strobes in;
//                         rdata (held) and rvalid (pulse) out
//   s_addr, s_wdata       register file address / write data (held when idle)
//   s_wr, s_rd            register file strobes, combinational from the granted slot
//   s_rdata               register file read data, valid the cycle after s_rd
//   err_clr               clears the sticky error flags
//   ovf[n]                sticky: a strobe from master n was dropped
//   conflict[n]           sticky: master n raised rd and wr in the same cycle
module reg_bus_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m0_wr,
  input  logic              m1_wr,
  input  logic              m0_rd,
  input  logic              m1_rd,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_wr,
  output logic              s_rd,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              err_clr,
  output logic [1:0]        ovf,
  output logic [1:0]        conflict
);

  logic [1:0]        wr_in;
  logic [1:0]        rd_in;
  logic [1:0]        strobe;
  logic [ADDR_W-1:0] addr_in  [2];
  logic [DATA_W-1:0] wdata_in [2];

  logic [1:0]        slot_valid;
  logic [1:0]        slot_is_wr;
  logic [ADDR_W-1:0] slot_addr  [2];
  logic [DATA_W-1:0] slot_wdata [2];

  logic              last_grant;
  logic              grant_any;
  logic              grant_idx;
  logic [1:0]        issued;

  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;

  logic              tag_valid;
  logic              tag_master;

  logic [1:0]        ovf_set;
  logic [1:0]        conflict_set;

  // Both masters are handled by index so the slot logic is written once.
  assign wr_in       = {m1_wr, m0_wr};
  assign rd_in       = {m1_rd, m0_rd};
  assign strobe      = wr_in | rd_in;
  assign addr_in[0]  = m0_addr;
  assign addr_in[1]  = m1_addr;
  assign wdata_in[0] = m0_wdata;
  assign wdata_in[1] = m1_wdata;

  // Grant selection. On a tie in round-robin mode, the master that was not
  // granted last wins. last_grant resets to 1, so master 0 takes the first tie.
  always_comb begin
    grant_any = |slot_valid;
    grant_idx = 1'b0;
    if (slot_valid == 2'b10) begin
      grant_idx = 1'b1;
    end else if (slot_valid == 2'b11 && FIXED_PRIO == 0) begin
      grant_idx = ~last_grant;
    end
    issued[0] = grant_any & ~grant_idx;
    issued[1] = grant_any &  grant_idx;
  end

  // The register file port is driven straight from the granted slot. When
  // idle, address and data hold the last issued values.
  always_comb begin
    s_wr    = 1'b0;
    s_rd    = 1'b0;
    s_addr  = hold_addr;
    s_wdata = hold_wdata;
    if (grant_any) begin
      s_wr    =  slot_is_wr[grant_idx];
      s_rd    = ~slot_is_wr[grant_idx];
      s_addr  =  slot_addr[grant_idx];
      s_wdata =  slot_wdata[grant_idx];
    end
  end

  // A slot accepts a strobe when it is empty or is being issued this cycle.
  // Otherwise the strobe is dropped and the old content is kept. When wr and
  // rd arrive together, the write is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      slot_is_wr <= '0;
      for (int n = 0; n < 2; n++) begin
        slot_addr[n]  <= '0;
        slot_wdata[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (strobe[n] && (!slot_valid[n] || issued[n])) begin
          slot_valid[n] <= 1'b1;
          slot_is_wr[n] <= wr_in[n];
          slot_addr[n]  <= addr_in[n];
          if (wr_in[n]) begin
            slot_wdata[n] <= wdata_in[n];
          end
        end else if (issued[n]) begin
          slot_valid[n] <= 1'b0;
        end
      end
    end
  end

  // Grant history and the held bus values for idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else if (grant_any) begin
      last_grant <= grant_idx;
      hold_addr  <= s_addr;
      hold_wdata <= s_wdata;
    end
  end

  // Read return pipeline. The tag records which master owns the read in
  // flight. On the following edge, s_rdata is captured for that master and
  // rvalid pulses. One tag is enough because s_rdata always comes back the
  // very next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid  <= 1'b0;
      tag_master <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
    end else begin
      tag_valid <= s_rd;
      if (s_rd) begin
        tag_master <= grant_idx;
      end
      m0_rvalid <= tag_valid & ~tag_master;
      m1_rvalid <= tag_valid &  tag_master;
      if (tag_valid && !tag_master) begin
        m0_rdata <= s_rdata;
      end
      if (tag_valid && tag_master) begin
        m1_rdata <= s_rdata;
      end
    end
  end

  // Sticky error flags. A new error in the same cycle as err_clr still sets
  // the flag.
  assign ovf_set      = strobe & slot_valid & ~issued;
  assign conflict_set = wr_in & rd_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= '0;
      conflict <= '0;
    end else begin
      ovf      <= (err_clr ? 2'b00 : ovf)      | ovf_set;
      conflict <= (err_clr ? 2'b00 : conflict) | conflict_set;
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter
// Drives one round-robin instance (index 0) and one fixed-priority instance
// (index 1) with the same master traffic. A transaction-level model predicts
// each register-file access and each read return, along with the cycle it
// should appear in. A monitor on the falling edge checks the DUT against
// those queues. The register file is emulated as data = addr ^ 8'hA7, and
// s_rdata carries random junk whenever no read is being answered.
module tb_reg_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic       m0_wr = 1'b0, m1_wr = 1'b0, m0_rd = 1'b0, m1_rd = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] s_addr_o   [2];
  logic [7:0] s_wdata_o  [2];
  logic       s_wr_o     [2];
  logic       s_rd_o     [2];
  logic [7:0] s_rdata_i  [2];
  logic [7:0] m0_rdata_o [2];
  logic [7:0] m1_rdata_o [2];
  logic       m0_rvalid_o[2];
  logic       m1_rvalid_o[2];
  logic [1:0] ovf_o      [2];
  logic [1:0] conflict_o [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_wr(m0_wr), .m1_wr(m1_wr), .m0_rd(m0_rd), .m1_rd(m1_rd),
    .m0_rdata(m0_rdata_o[0]), .m1_rdata(m1_rdata_o[0]),
    .m0_rvalid(m0_rvalid_o[0]), .m1_rvalid(m1_rvalid_o[0]),
    .s_addr(s_addr_o[0]), .s_wdata(s_wdata_o[0]), .s_wr(s_wr_o[0]), .s_rd(s_rd_o[0]),
    .s_rdata(s_rdata_i[0]), .err_clr(err_clr), .ovf(ovf_o[0]), .conflict(conflict_o[0])
  );

  reg_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_wr(m0_wr), .m1_wr(m1_wr), .m0_rd(m0_rd), .m1_rd(m1_rd),
    .m0_rdata(m0_rdata_o[1]), .m1_rdata(m1_rdata_o[1]),
    .m0_rvalid(m0_rvalid_o[1]), .m1_rvalid(m1_rvalid_o[1]),
    .s_addr(s_addr_o[1]), .s_wdata(s_wdata_o[1]), .s_wr(s_wr_o[1]), .s_rd(s_rd_o[1]),
    .s_rdata(s_rdata_i[1]), .err_clr(err_clr), .ovf(ovf_o[1]), .conflict(conflict_o[1])
  );

  // Register file stand-in: answers a read on the next cycle, junk otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      s_rdata_i[k] <= s_rd_o[k] ? (s_addr_o[k] ^ 8'hA7) : 8'($urandom);
    end
  end

  typedef struct {
    int         inst;
    int         cyc;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_t;

  typedef struct {
    int         inst;
    int         mst;
    int         cyc;
    logic [7:0] data;
  } ret_t;

  bus_t bus_q[$];
  ret_t ret_q[$];

  // Reference model: what each master has waiting, plus error flags.
  bit         pv [2][2];
  bit         pw [2][2];
  logic [7:0] pa [2][2];
  logic [7:0] pd [2][2];
  int         last_g   [2];
  logic [1:0] movf     [2];
  logic [1:0] mconf    [2];
  logic [1:0] snap_ovf [2];
  logic [1:0] snap_conf[2];
  logic [7:0] last_addr[2];

  task automatic check_output(input string name, input int inst,
                              input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s inst=%0d cycle=%0d: got %0h expected %0h",
               name, inst, cyc, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        pv[k][m] = 1'b0;
        pw[k][m] = 1'b0;
        pa[k][m] = '0;
        pd[k][m] = '0;
      end
      last_g[k]    = 1;
      movf[k]      = '0;
      mconf[k]     = '0;
      snap_ovf[k]  = '0;
      snap_conf[k] = '0;
      last_addr[k] = '0;
    end
    bus_q.delete();
    ret_q.delete();
  endfunction

  // One cycle of instance k. Whatever is waiting at the start of the cycle
  // competes for the bus. The winner goes out this cycle, and a read returns
  // two cycles later. New strobes then go into free (or just freed) places.
  task automatic model_step(input int k);
    int         g;
    logic [1:0] wv, rv, new_ovf, new_conf;
    logic [7:0] av [2];
    logic [7:0] dv [2];
    wv = {m1_wr, m0_wr};
    rv = {m1_rd, m0_rd};
    av[0] = m0_addr;  av[1] = m1_addr;
    dv[0] = m0_wdata; dv[1] = m1_wdata;
    snap_ovf[k]  = movf[k];
    snap_conf[k] = mconf[k];
    g = -1;
    if (pv[k][0] && pv[k][1]) g = (k == 1) ? 0 : ((last_g[k] == 0) ? 1 : 0);
    else if (pv[k][0]) g = 0;
    else if (pv[k][1]) g = 1;
    if (g >= 0) begin
      bus_q.push_back('{k, cyc, pw[k][g], pa[k][g], pd[k][g]});
      if (!pw[k][g]) ret_q.push_back('{k, g, cyc + 2, pa[k][g] ^ 8'hA7});
      last_g[k]    = g;
      last_addr[k] = pa[k][g];
      pv[k][g]     = 1'b0;
    end
    new_ovf  = '0;
    new_conf = '0;
    for (int m = 0; m < 2; m++) begin
      if (wv[m] || rv[m]) begin
        if (wv[m] && rv[m]) new_conf[m] = 1'b1;
        if (pv[k][m]) begin
          new_ovf[m] = 1'b1;
        end else begin
          pv[k][m] = 1'b1;
          pw[k][m] = wv[m];
          pa[k][m] = av[m];
          pd[k][m] = dv[m];
        end
      end
    end
    movf[k]  = (err_clr ? 2'b00 : movf[k])  | new_ovf;
    mconf[k] = (err_clr ? 2'b00 : mconf[k]) | new_conf;
  endtask

  task automatic apply_stimulus(input bit w0, input bit r0, input logic [7:0] a0,
                                input logic [7:0] d0, input bit w1, input bit r1,
                                input logic [7:0] a1, input logic [7:0] d1,
                                input bit clr);
    @(posedge clk);
    #1;
    m0_wr = w0; m0_rd = r0; m0_addr = a0; m0_wdata = d0;
    m1_wr = w1; m1_rd = r1; m1_addr = a1; m1_wdata = d1;
    err_clr = clr;
    model_step(0);
    model_step(1);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m0_wr = 0; m0_rd = 0; m1_wr = 0; m1_rd = 0; err_clr = 0;
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops expectations due in the current cycle and compares them
  // with what the DUT presents.
  always @(negedge clk) begin : monitor
    bit         hit;
    bus_t       eb;
    ret_t       er;
    logic       rv;
    logic [7:0] rd;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        check_output("reset_outputs", k,
          64'({s_addr_o[k], s_wdata_o[k], s_wr_o[k], s_rd_o[k], m0_rdata_o[k],
               m1_rdata_o[k], m0_rvalid_o[k], m1_rvalid_o[k], ovf_o[k], conflict_o[k]}),
          64'd0);
      end else begin
        check_output("ovf", k, 64'(ovf_o[k]), 64'(snap_ovf[k]));
        check_output("conflict", k, 64'(conflict_o[k]), 64'(snap_conf[k]));
        hit = 1'b0;
        foreach (bus_q[j]) begin
          if (bus_q[j].inst == k && bus_q[j].cyc == cyc) begin
            hit = 1'b1;
            eb  = bus_q[j];
          end
        end
        check_output("bus_access", k, 64'(s_wr_o[k] | s_rd_o[k]), 64'(hit));
        if (hit && (s_wr_o[k] || s_rd_o[k])) begin
          check_output("bus_cmd", k, 64'({s_wr_o[k], s_rd_o[k], s_addr_o[k]}),
                       64'({eb.wr, !eb.wr, eb.addr}));
          if (eb.wr) check_output("bus_wdata", k, 64'(s_wdata_o[k]), 64'(eb.data));
        end else if (!hit) begin
          check_output("idle_addr_hold", k, 64'(s_addr_o[k]), 64'(last_addr[k]));
        end
        for (int j = bus_q.size() - 1; j >= 0; j--) begin
          if (bus_q[j].inst == k && bus_q[j].cyc <= cyc) bus_q.delete(j);
        end
        for (int m = 0; m < 2; m++) begin
          rv  = (m == 0) ? m0_rvalid_o[k] : m1_rvalid_o[k];
          rd  = (m == 0) ? m0_rdata_o[k]  : m1_rdata_o[k];
          hit = 1'b0;
          foreach (ret_q[j]) begin
            if (ret_q[j].inst == k && ret_q[j].mst == m && ret_q[j].cyc == cyc) begin
              hit = 1'b1;
              er  = ret_q[j];
            end
          end
          check_output((m == 0) ? "m0_rvalid" : "m1_rvalid", k, 64'(rv), 64'(hit));
          if (hit && rv) begin
            check_output((m == 0) ? "m0_rdata" : "m1_rdata", k, 64'(rd), 64'(er.data));
          end
          for (int j = ret_q.size() - 1; j >= 0; j--) begin
            if (ret_q[j].inst == k && ret_q[j].mst == m && ret_q[j].cyc <= cyc) begin
              ret_q.delete(j);
            end
          end
        end
      end
    end
  end

  initial begin
    int leftover;
    int sel;
    bit w0, r0, w1, r1;

    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] solo write");
    apply_stimulus(1, 0, 8'h05, 8'h55, 0, 0, 8'h00, 8'h00, 0);
    idle(4);

    $display("[TB] solo read");
    apply_stimulus(0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 0);
    idle(5);

    $display("[TB] simultaneous reads after reset");
    do_reset(2);
    apply_stimulus(0, 1, 8'h01, 8'h00, 0, 1, 8'h02, 8'h00, 0);
    idle(6);

    $display("[TB] overflow");
    apply_stimulus(1, 0, 8'h10, 8'h11, 1, 0, 8'h12, 8'h13, 0);
    apply_stimulus(1, 0, 8'h14, 8'h15, 1, 0, 8'h16, 8'h17, 0);
    idle(4);
    check_output("ovf_fixed_prio", 1, 64'(ovf_o[1]), 64'(2'b10));
    apply_stimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1);
    idle(2);
    check_output("ovf_cleared", 1, 64'(ovf_o[1]), 64'd0);

    $display("[TB] conflict");
    apply_stimulus(1, 1, 8'h20, 8'hF0, 0, 0, 8'h00, 8'h00, 0);
    idle(4);
    check_output("conflict_m0", 0, 64'(conflict_o[0]), 64'(2'b01));
    check_output("conflict_m0", 1, 64'(conflict_o[1]), 64'(2'b01));
    apply_stimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1);
    idle(2);

    $display("[TB] reset during read");
    apply_stimulus(0, 0, 8'h00, 8'h00, 0, 1, 8'h33, 8'h00, 0);
    idle(1);
    do_reset(2);
    idle(5);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(2);
      sel = $urandom_range(0, 9);
      w0  = (sel >= 7);
      r0  = (sel >= 4 && sel <= 6) || sel == 9;
      sel = $urandom_range(0, 9);
      w1  = (sel >= 7);
      r1  = (sel >= 4 && sel <= 6) || sel == 9;
      apply_stimulus(w0, r0, 8'($urandom), 8'($urandom),
                     w1, r1, 8'($urandom), 8'($urandom),
                     ($urandom_range(0, 15) == 0));
    end
    idle(8);

    for (int k = 0; k < 2; k++) begin
      leftover = 0;
      foreach (bus_q[j]) if (bus_q[j].inst == k) leftover++;
      foreach (ret_q[j]) if (ret_q[j].inst == k) leftover++;
      check_output("leftover_expected", k, 64'(leftover), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
